id_scoreboard: RTL and testbench
================================

ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, architectural register count; index width RAW = clog2(NUM_REGS).
REQ-002 Parameter MAX_LAT, default 4, largest fixed latency in cycles; counter width LW = clog2(MAX_LAT+1).
REQ-003 Parameter MAX_OUT, default 2, maximum in-flight long-latency (variable-latency) ops.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_issue_valid  in  1  decode stage presents an instruction this cycle.
REQ-007 i_Rs1 / i_Rs2  in  RAW each  source register indices.
REQ-008 i_use_Rs1 / i_use_Rs2  in  1 each  instruction actually reads that source.
REQ-009 i_Rd  in  RAW  destination index.
REQ-010 i_ctrl_RegWrite  in  1  instruction writes i_Rd.
REQ-011 i_ctrl_Long  in  1  destination completes at variable latency via completion port.
REQ-012 i_Lat  in  LW  fixed result latency, 1..MAX_LAT, used when i_ctrl_Long=0.
REQ-013 i_flush  in  1  kill the presented instruction (branch/jump redirect).
REQ-014 i_cmpl_valid / i_cmpl_Rd  in  1 / RAW  long-latency result written back this cycle.
REQ-015 o_stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-016 o_long_cnt  out  clog2(MAX_OUT+1)  in-flight long ops.
REQ-017 o_idle  out  1  no register pending.
REQ-018 o_err  out  1  sticky protocol error flag.

Function
REQ-019 State per register r: long bit L[r], countdown C[r] (LW bits); pending[r] = L[r] | (C[r]!=0); register 0 never pending, never written.
REQ-020 Hazard when i_issue_valid & ~i_flush and any of: i_use_Rs1 & pending[i_Rs1] (RAW), i_use_Rs2 & pending[i_Rs2] (RAW), i_ctrl_RegWrite & pending[i_Rd] (WAW), i_ctrl_Long & i_ctrl_RegWrite & o_long_cnt==MAX_OUT (capacity).
REQ-021 o_stall is combinational = hazard; zero-cycle latency from inputs.
REQ-022 Issue fires when i_issue_valid & ~i_flush & ~o_stall & i_ctrl_RegWrite & i_Rd!=0.
REQ-023 Fixed issue: C[i_Rd] loads i_Lat next edge; i_Lat=0 or >MAX_LAT loads MAX_LAT and sets o_err.
REQ-024 Long issue: L[i_Rd] set next edge; o_long_cnt increments.
REQ-025 Every nonzero C[r] decrements by 1 each cycle; zero holds.
REQ-026 Completion: i_cmpl_valid & L[i_cmpl_Rd] clears L[i_cmpl_Rd] and decrements o_long_cnt; completion to non-long register is ignored and sets o_err.
REQ-027 Simultaneous long issue and completion: o_long_cnt unchanged; same register cannot coincide since WAW stalls issue.
REQ-028 "Resolving this cycle" for r: C[r]==1, or i_cmpl_valid & i_cmpl_Rd==r & L[r].
REQ-029 i_flush suppresses issue and hazard same cycle; pending state continues to age/complete normally.
REQ-030 o_idle = no pending[r] for all r, registered view (current state).
REQ-031 o_long_cnt never exceeds MAX_OUT or underflows.

Reset
REQ-032 rst asserted: all L[r]=0, C[r]=0, o_long_cnt=0, o_err=0 immediately; o_idle=1, o_stall=0 unless inputs raise a hazard (none possible with empty state).
REQ-033 rst mid-operation discards all in-flight tracking; later completions for discarded ops set o_err.

Configuration
REQ-034 Macro SCOREBOARD_BYPASS_EN defined: register resolving this cycle (REQ-028) causes no RAW/WAW hazard (forwarding supplies value); undefined: it still stalls, releasing one cycle later.

Verification
REQ-035 Issue rd=5, Lat=3; next cycles rs1=5 -> o_stall 1,1 then 0 (bypass) or 1,1,1 then 0 (no bypass).
REQ-036 Long issue rd=7, then rs2=7 -> stall until i_cmpl_valid rd=7; o_long_cnt 1->0; stall drops same cycle with bypass, next cycle without.
REQ-037 Two long issues rd=1, rd=2 (MAX_OUT=2), third long rd=3 -> o_stall=1 until a completion; o_long_cnt peaks 2.
REQ-038 Issue rd=0 Lat=2 then rs1=0 -> never stalls; o_idle stays 1.
REQ-039 RAW hazard present with i_flush=1 -> o_stall=0, no state change; completion rd=9 with L[9]=0 -> o_err=1, sticky.
REQ-040 Long issue rd=4, assert rst one cycle -> o_long_cnt=0, o_idle=1; later completion rd=4 -> o_err=1.

Source files
------------

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending tracker for in-order issue; o_stall is combinational, state updates next edge.
// Backpressure: o_stall holds decode. SCOREBOARD_BYPASS_EN: registers resolving this cycle forward instead of stalling.
module id_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 4,
  parameter int MAX_OUT  = 2,
  localparam int RAW = $clog2(NUM_REGS),
  localparam int LW  = $clog2(MAX_LAT + 1),
  localparam int CW  = $clog2(MAX_OUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_issue_valid,
  input  logic [RAW-1:0] i_Rs1,
  input  logic [RAW-1:0] i_Rs2,
  input  logic           i_use_Rs1,
  input  logic           i_use_Rs2,
  input  logic [RAW-1:0] i_Rd,
  input  logic           i_ctrl_RegWrite,
  input  logic           i_ctrl_Long,
  input  logic [LW-1:0]  i_Lat,
  input  logic           i_flush,
  input  logic           i_cmpl_valid,
  input  logic [RAW-1:0] i_cmpl_Rd,
  output logic           o_stall,
  output logic [CW-1:0]  o_long_cnt,
  output logic           o_idle,
  output logic           o_err
);

  logic [NUM_REGS-1:0] long_q;
  logic [LW-1:0]       cnt_q [NUM_REGS];
  logic [CW-1:0]       long_cnt_q;
  logic                err_q;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] blocking;
`ifdef SCOREBOARD_BYPASS_EN
  logic [NUM_REGS-1:0] resolving;
`endif

  logic hazard, fire, fix_fire, long_fire, lat_bad, cmpl_hit, cmpl_stray;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = (r != 0) && (long_q[r] || (cnt_q[r] != '0));
`ifdef SCOREBOARD_BYPASS_EN
      // A value landing this cycle is forwarded, so it no longer blocks.
      resolving[r] = (cnt_q[r] == LW'(1)) ||
                     (i_cmpl_valid && (i_cmpl_Rd == RAW'(r)) && long_q[r]);
      blocking[r]  = pending[r] && !resolving[r];
`else
      blocking[r]  = pending[r];
`endif
    end
  end

  always_comb begin
    hazard = i_issue_valid && !i_flush &&
             ((i_use_Rs1 && blocking[i_Rs1]) ||
              (i_use_Rs2 && blocking[i_Rs2]) ||
              (i_ctrl_RegWrite && blocking[i_Rd]) ||
              (i_ctrl_Long && i_ctrl_RegWrite && (long_cnt_q == CW'(MAX_OUT))));
    fire       = i_issue_valid && !i_flush && !hazard && i_ctrl_RegWrite && (i_Rd != '0);
    fix_fire   = fire && !i_ctrl_Long;
    long_fire  = fire && i_ctrl_Long;
    lat_bad    = (i_Lat == '0) || (i_Lat > LW'(MAX_LAT));
    cmpl_hit   = i_cmpl_valid && long_q[i_cmpl_Rd];
    cmpl_stray = i_cmpl_valid && !long_q[i_cmpl_Rd];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_q     <= '0;
      long_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - LW'(1);
      end
      if (cmpl_hit) long_q[i_cmpl_Rd] <= 1'b0;
      // A new issue overrides aging/completion on the same register.
      if (fix_fire)  cnt_q[i_Rd]  <= lat_bad ? LW'(MAX_LAT) : i_Lat;
      if (long_fire) long_q[i_Rd] <= 1'b1;
      case ({long_fire, cmpl_hit})
        2'b10:   long_cnt_q <= long_cnt_q + CW'(1);
        2'b01:   long_cnt_q <= long_cnt_q - CW'(1);
        default: long_cnt_q <= long_cnt_q;
      endcase
      if ((fix_fire && lat_bad) || cmpl_stray) err_q <= 1'b1;
    end
  end

  assign o_stall    = hazard;
  assign o_long_cnt = long_cnt_q;
  assign o_idle     = ~|pending;
  assign o_err      = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with a time-based reference model checked every cycle.
module tb_id_scoreboard;
  localparam int NR = 32;
  localparam int ML = 4;
  localparam int MO = 2;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, use1, use2, rw, lng, flush, cmpl_valid;
  logic [4:0] rs1, rs2, rd, cmpl_rd;
  logic [2:0] lat;
  logic       o_stall, o_idle, o_err;
  logic [1:0] o_long_cnt;

  int checks = 0;
  int errors = 0;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .i_issue_valid(valid), .i_Rs1(rs1), .i_Rs2(rs2),
    .i_use_Rs1(use1), .i_use_Rs2(use2), .i_Rd(rd), .i_ctrl_RegWrite(rw),
    .i_ctrl_Long(lng), .i_Lat(lat), .i_flush(flush), .i_cmpl_valid(cmpl_valid),
    .i_cmpl_Rd(cmpl_rd), .o_stall(o_stall), .o_long_cnt(o_long_cnt),
    .o_idle(o_idle), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Reference model: a fixed-latency result is available at absolute cycle ready[r];
  // long ops are a set of outstanding registers.
  int cyc = 0;
  int ready [NR];
  bit mlong [NR];
  int mcnt = 0;
  bit merr = 1'b0;
  bit m_hz, m_fire;
  int m_l;

  function automatic bit pend(int r);
    return (r != 0) && (mlong[r] || (cyc < ready[r]));
  endfunction

  function automatic bit blk(int r);
    bit res;
    res = (cyc == ready[r] - 1) || (cmpl_valid && (int'(cmpl_rd) == r) && mlong[r]);
    return pend(r) && !(BYP && res);
  endfunction

  function automatic bit exp_stall();
    return valid && !flush &&
           ((use1 && blk(int'(rs1))) || (use2 && blk(int'(rs2))) ||
            (rw && blk(int'(rd))) || (lng && rw && (mcnt == MO)));
  endfunction

  function automatic bit exp_idle();
    for (int r = 0; r < NR; r++) if (pend(r)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        ready[r] = 0;
        mlong[r] = 1'b0;
      end
      mcnt = 0;
      merr = 1'b0;
    end else begin
      m_hz   = exp_stall();
      m_fire = valid && !flush && !m_hz && rw && (rd != 5'd0);
      if (cmpl_valid) begin
        if (mlong[int'(cmpl_rd)]) begin
          mlong[int'(cmpl_rd)] = 1'b0;
          mcnt = mcnt - 1;
        end else begin
          merr = 1'b1;
        end
      end
      cyc = cyc + 1;
      if (m_fire && lng) begin
        mlong[int'(rd)] = 1'b1;
        mcnt = mcnt + 1;
      end else if (m_fire) begin
        m_l = int'(lat);
        if (m_l == 0 || m_l > ML) begin
          m_l  = ML;
          merr = 1'b1;
        end
        ready[int'(rd)] = cyc + m_l;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_stall", int'(o_stall), int'(exp_stall()));
    chk("model_long_cnt", int'(o_long_cnt), mcnt);
    chk("model_idle", int'(o_idle), int'(exp_idle()));
    chk("model_err", int'(o_err), int'(merr));
  end

  task automatic clr();
    valid = 0; use1 = 0; use2 = 0; rw = 0; lng = 0; flush = 0; cmpl_valid = 0;
    rs1 = '0; rs2 = '0; rd = '0; cmpl_rd = '0; lat = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic issue_fix(input logic [4:0] d, input logic [2:0] l);
    clr(); valid = 1; rw = 1; rd = d; lat = l;
  endtask

  task automatic issue_long(input logic [4:0] d);
    clr(); valid = 1; rw = 1; lng = 1; rd = d;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    at_neg();
    chk("rst_long_cnt", int'(o_long_cnt), 0);
    chk("rst_idle", int'(o_idle), 1);
    chk("rst_err", int'(o_err), 0);
    chk("rst_stall", int'(o_stall), 0);
    nxt();
    rst = 1'b0;

    // Fixed latency RAW: rd=5 Lat=3, then a reader of r5
    issue_fix(5'd5, 3'd3);
    at_neg(); chk("t35_issue", int'(o_stall), 0); nxt();
    clr(); valid = 1; use1 = 1; rs1 = 5'd5;
    for (int i = 0; i < (BYP ? 2 : 3); i++) begin
      at_neg(); chk("t35_stall", int'(o_stall), 1); nxt();
    end
    at_neg(); chk("t35_release", int'(o_stall), 0); nxt();
    clr();

    // Long op on r7 with a reader of r7 via rs2
    issue_long(5'd7);
    at_neg(); chk("t36_issue", int'(o_stall), 0); nxt();
    clr(); valid = 1; use2 = 1; rs2 = 5'd7;
    at_neg(); chk("t36_stall", int'(o_stall), 1); chk("t36_cnt1", int'(o_long_cnt), 1); nxt();
    at_neg(); chk("t36_stall2", int'(o_stall), 1); nxt();
    cmpl_valid = 1; cmpl_rd = 5'd7;
    at_neg(); chk("t36_cmpl_cycle", int'(o_stall), BYP ? 0 : 1); nxt();
    cmpl_valid = 0;
    if (BYP) valid = 0;
    at_neg(); chk("t36_after", int'(o_stall), 0); chk("t36_cnt0", int'(o_long_cnt), 0); nxt();
    clr();

    // Capacity: two long ops outstanding, third waits for a completion
    issue_long(5'd1);
    at_neg(); chk("t37_l1", int'(o_stall), 0); nxt();
    issue_long(5'd2);
    at_neg(); chk("t37_l2", int'(o_stall), 0); chk("t37_cnt1", int'(o_long_cnt), 1); nxt();
    issue_long(5'd3);
    at_neg(); chk("t37_cap", int'(o_stall), 1); chk("t37_peak", int'(o_long_cnt), 2); nxt();
    at_neg(); chk("t37_cap2", int'(o_stall), 1); nxt();
    cmpl_valid = 1; cmpl_rd = 5'd1;
    at_neg(); chk("t37_cap_cmpl", int'(o_stall), 1); nxt();
    cmpl_valid = 0;
    at_neg(); chk("t37_go", int'(o_stall), 0); chk("t37_cnt_dip", int'(o_long_cnt), 1); nxt();
    clr();
    at_neg(); chk("t37_cnt_back", int'(o_long_cnt), 2); nxt();
    cmpl_valid = 1; cmpl_rd = 5'd2; nxt();
    cmpl_rd = 5'd3; nxt();
    clr();
    at_neg(); chk("t37_drained", int'(o_long_cnt), 0); chk("t37_idle", int'(o_idle), 1); nxt();

    // Register 0 is never pending
    issue_fix(5'd0, 3'd2);
    at_neg(); chk("t38_issue", int'(o_stall), 0); nxt();
    clr(); valid = 1; use1 = 1; rs1 = 5'd0; rw = 1; rd = 5'd0; lat = 3'd2;
    at_neg(); chk("t38_rs0", int'(o_stall), 0); chk("t38_idle", int'(o_idle), 1); nxt();
    clr();

    // Flush kills hazard and issue; stray completion flags error
    issue_fix(5'd6, 3'd4); nxt();
    clr(); valid = 1; use1 = 1; rs1 = 5'd6; flush = 1; rw = 1; rd = 5'd10; lat = 3'd2;
    at_neg(); chk("t39_flush", int'(o_stall), 0); nxt();
    clr(); valid = 1; use1 = 1; rs1 = 5'd10;
    at_neg(); chk("t39_no_issue", int'(o_stall), 0); nxt();
    clr(); cmpl_valid = 1; cmpl_rd = 5'd9;
    at_neg(); chk("t39_err_before", int'(o_err), 0); nxt();
    clr();
    at_neg(); chk("t39_err", int'(o_err), 1); nxt();
    repeat (3) nxt();
    at_neg(); chk("t39_sticky", int'(o_err), 1); nxt();

    // Reset mid-flight drops tracking; late completion is an error
    issue_long(5'd4); nxt();
    clr();
    at_neg(); chk("t40_cnt1", int'(o_long_cnt), 1);
    #2 rst = 1'b1;
    #1;
    chk("t40_rst_cnt", int'(o_long_cnt), 0);
    chk("t40_rst_idle", int'(o_idle), 1);
    chk("t40_rst_err", int'(o_err), 0);
    nxt();
    rst = 1'b0;
    cmpl_valid = 1; cmpl_rd = 5'd4;
    at_neg(); chk("t40_err_before", int'(o_err), 0); nxt();
    clr();
    at_neg(); chk("t40_err", int'(o_err), 1); nxt();

    // Out-of-range latencies clamp to MAX_LAT and flag error
    rst = 1'b1; nxt(); rst = 1'b0;
    issue_fix(5'd11, 3'd0);
    at_neg(); chk("lat0_err_before", int'(o_err), 0); nxt();
    clr(); valid = 1; use1 = 1; rs1 = 5'd11;
    at_neg(); chk("lat0_err", int'(o_err), 1);
    for (int i = 0; i < (BYP ? ML - 1 : ML); i++) begin
      if (i > 0) at_neg();
      chk("lat0_stall", int'(o_stall), 1); nxt();
    end
    at_neg(); chk("lat0_release", int'(o_stall), 0); nxt();
    issue_fix(5'd12, 3'd7); nxt();
    clr(); valid = 1; use2 = 1; rs2 = 5'd12;
    at_neg(); chk("lat7_stall", int'(o_stall), 1); nxt();
    clr();
    repeat (ML + 1) nxt();
    at_neg(); chk("final_idle", int'(o_idle), 1); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
